// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, two prioritised write ports,
// optional zero entry, write bypass and registered reads; self-clears after reset.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   we0/waddr0/wdata0 write port 0
//   we1/waddr1/wdata1 write port 1 (wins over port 0 on equal address)
//   raddr             NRP packed read addresses, lane k at [k*AW +: AW]
//   rdata             NRP packed read data, lane k at [k*W +: W]
//   ready             high once the array has been cleared
//   wr_conflict       pulse: both ports hit the same address last cycle

module regfile_mp #(
  parameter int W        = 32,
  parameter int DEPTH    = 32,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int REG_RD   = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [W-1:0]      wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [W-1:0]      wdata1,
  input  logic [NRP*AW-1:0] raddr,
  output logic [NRP*W-1:0]  rdata,
  output logic              ready,
  output logic              wr_conflict
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic [AW-1:0] ptr_rst;

  logic          run;
  logic          zero0;
  logic          zero1;
  logic          same;
  logic          wr0;
  logic          wr1;
  logic          conf_q;
  logic          conf_d;

  logic [W-1:0]  mem [DEPTH];

  logic [NRP*W-1:0] rval;

  // Entry 0 is never written when hardwired, so the sweep skips it.
  assign ptr_rst = (ZERO_REG != 0) ? AW'(1) : '0;

  assign run   = (state_q == RUN);
  assign ready = run;

  assign zero0 = (ZERO_REG != 0) && (waddr0 == '0);
  assign zero1 = (ZERO_REG != 0) && (waddr1 == '0);
  assign same  = (waddr0 == waddr1);

  // Port 0 is suppressed on a collision so port 1 wins outright.
  assign wr0 = run && we0 && !zero0 && !(we1 && same);
  assign wr1 = run && we1 && !zero1;

  assign conf_d = run && we0 && we1 && same && !zero1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ptr_d = ptr_q;
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = ptr_rst;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
      ptr_q   <= ptr_rst;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      conf_q  <= conf_d;
    end
  end

  assign wr_conflict = conf_q;

  // Storage carries no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!run) begin
        mem[ptr_q] <= '0;
      end else begin
        if (wr0) begin
          mem[waddr0] <= wdata0;
        end
        if (wr1) begin
          mem[waddr1] <= wdata1;
        end
      end
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [W-1:0]  v;
    logic          hit0;
    logic          hit1;

    assign ra   = raddr[k*AW +: AW];
    assign hit0 = (BYPASS != 0) && we0 && (waddr0 == ra);
    assign hit1 = (BYPASS != 0) && we1 && (waddr1 == ra);

    // Later assignments win: zero/clear masking beats port 1 beats port 0.
    always_comb begin
      v = mem[ra];
      if (hit0) begin
        v = wdata0;
      end
      if (hit1) begin
        v = wdata1;
      end
      if (!run || ((ZERO_REG != 0) && (ra == '0))) begin
        v = '0;
      end
    end

    assign rval[k*W +: W] = v;
  end

  if (REG_RD != 0) begin : g_reg
    logic [NRP*W-1:0] rq;

    // rval is already zero while clearing, so no extra gating here.
    always_ff @(posedge clk) begin
      if (!rst) begin
        rq <= '0;
      end else begin
        rq <= rval;
      end
    end

    assign rdata = rq;
  end else begin : g_comb
    assign rdata = rval;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with a queue scoreboard.
// Three instances: combinational+bypass, no-bypass, registered 3-lane.

module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        we0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic [9:0]  ra2;
  logic [14:0] ra3;

  logic [63:0] da_rd;
  logic [63:0] db_rd;
  logic [95:0] dc_rd;
  logic        da_rdy;
  logic        db_rdy;
  logic        dc_rdy;
  logic        da_cf;
  logic        db_cf;
  logic        dc_cf;

  int n_chk;
  int n_pass;
  int n;
  logic [31:0] exp_q[$];

  regfile_mp #(
    .W(32), .DEPTH(32), .NRP(2),
    .ZERO_REG(1), .BYPASS(1), .REG_RD(0)
  ) da (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(ra2), .rdata(da_rd),
    .ready(da_rdy), .wr_conflict(da_cf)
  );

  regfile_mp #(
    .W(32), .DEPTH(32), .NRP(2),
    .ZERO_REG(1), .BYPASS(0), .REG_RD(0)
  ) db (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(ra2), .rdata(db_rd),
    .ready(db_rdy), .wr_conflict(db_cf)
  );

  regfile_mp #(
    .W(32), .DEPTH(32), .NRP(3),
    .ZERO_REG(1), .BYPASS(1), .REG_RD(1)
  ) dc (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(ra3), .rdata(dc_rd),
    .ready(dc_rdy), .wr_conflict(dc_cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_chk++;
    assert (got === e) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, e);
  endtask

  task automatic wr_off();
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    we0    = 1'b0;
    we1    = 1'b0;
    waddr0 = '0;
    waddr1 = '0;
    wdata0 = '0;
    wdata1 = '0;
    ra2    = '0;
    ra3    = '0;

    // reset held for 3 cycles
    tick(); tick(); tick();
    exp_q.push_back(32'd0); chk("rst_ready", {31'd0, da_rdy});
    exp_q.push_back(32'd0); chk("rst_conf", {31'd0, da_cf});
    exp_q.push_back(32'd0); chk("rst_dc_rd0", dc_rd[31:0]);
    exp_q.push_back(32'd0); chk("rst_dc_rd2", dc_rd[95:64]);

    // clear sequence length
    rst = 1'b1;
    ra2 = {5'd3, 5'd20};
    n = 0;
    while (!da_rdy && n < 40) begin
      tick();
      n++;
      if (n == 5) begin
        exp_q.push_back(32'd0);
        chk("clear_rd_forced0", da_rd[31:0]);
        exp_q.push_back(32'd0);
        chk("clear_rd_nobyp0", db_rd[63:32]);
      end
    end
    exp_q.push_back(32'd31); chk("clear_len", n);
    exp_q.push_back(32'd1); chk("ready_db", {31'd0, db_rdy});
    exp_q.push_back(32'd1); chk("ready_dc", {31'd0, dc_rdy});

    for (int a = 0; a < 32; a++) begin
      ra2 = {5'(a), 5'(a)};
      #1;
      exp_q.push_back(32'd0);
      chk("cleared", da_rd[63:32]);
    end

    // dual write
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h12345678;
    tick();
    wr_off();
    ra2 = {5'd6, 5'd5};
    #1;
    exp_q.push_back(32'hDEADBEEF); chk("dual_rd5", db_rd[31:0]);
    exp_q.push_back(32'h12345678); chk("dual_rd6", db_rd[63:32]);
    exp_q.push_back(32'd0); chk("dual_noconf", {31'd0, da_cf});

    // conflict on addr 7
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2;
    tick();
    wr_off();
    ra2 = {5'd7, 5'd7};
    #1;
    exp_q.push_back(32'h2); chk("conf_rd7", db_rd[31:0]);
    exp_q.push_back(32'd1); chk("conf_pulse", {31'd0, da_cf});
    tick();
    exp_q.push_back(32'd0); chk("conf_drop", {31'd0, da_cf});

    // conflict on addr 0 is ignored
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h2;
    tick();
    wr_off();
    ra2 = {5'd0, 5'd0};
    #1;
    exp_q.push_back(32'd0); chk("conf0_nopulse", {31'd0, da_cf});
    exp_q.push_back(32'd0); chk("conf0_rd", db_rd[31:0]);

    // bypass, both ports on different addresses
    ra2 = {5'd10, 5'd9};
    we0 = 1'b1; waddr0 = 5'd9;  wdata0 = 32'hA5A5A5A5;
    we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h5A5A5A5A;
    #1;
    exp_q.push_back(32'hA5A5A5A5); chk("byp_p0", da_rd[31:0]);
    exp_q.push_back(32'h5A5A5A5A); chk("byp_p1", da_rd[63:32]);
    exp_q.push_back(32'd0); chk("nobyp_old", db_rd[31:0]);
    tick();
    wr_off();
    #1;
    exp_q.push_back(32'hA5A5A5A5); chk("nobyp_after", db_rd[31:0]);

    // bypass priority on same address
    ra2 = {5'd11, 5'd11};
    we0 = 1'b1; waddr0 = 5'd11; wdata0 = 32'h1111;
    we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h2222;
    #1;
    exp_q.push_back(32'h2222); chk("byp_prio", da_rd[63:32]);
    tick();
    wr_off();

    // registered reads
    ra3 = '0;
    we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h22;
    tick();
    we1 = 1'b0;
    waddr0 = 5'd3; wdata0 = 32'h33;
    tick();
    wr_off();
    ra3 = {5'd3, 5'd2, 5'd1};
    #1;
    exp_q.push_back(32'd0); chk("rr_early0", dc_rd[31:0]);
    exp_q.push_back(32'd0); chk("rr_early2", dc_rd[95:64]);
    tick();
    exp_q.push_back(32'h11); chk("rr_l0", dc_rd[31:0]);
    exp_q.push_back(32'h22); chk("rr_l1", dc_rd[63:32]);
    exp_q.push_back(32'h33); chk("rr_l2", dc_rd[95:64]);

    // registered read captures bypassed write data
    ra3 = {5'd3, 5'd2, 5'd4};
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44;
    tick();
    wr_off();
    exp_q.push_back(32'h44); chk("rr_byp", dc_rd[31:0]);

    // mid-operation reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ra2 = {5'd6, 5'd5};
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hFFFFFFFF;
    #1;
    exp_q.push_back(32'd0); chk("mid_ready", {31'd0, da_rdy});
    exp_q.push_back(32'd0); chk("mid_conf", {31'd0, da_cf});
    exp_q.push_back(32'd0); chk("mid_rd_byp", da_rd[31:0]);
    exp_q.push_back(32'd0); chk("mid_rd_old", db_rd[63:32]);
    exp_q.push_back(32'd0); chk("mid_dc", dc_rd[63:32]);
    tick();
    n = 1;
    wr_off();
    while (!da_rdy && n < 40) begin
      tick();
      n++;
    end
    exp_q.push_back(32'd31); chk("mid_clear_len", n);

    for (int a = 0; a < 32; a++) begin
      ra2 = {5'(a), 5'(a)};
      #1;
      exp_q.push_back(32'd0);
      chk("mid_cleared", da_rd[63:32]);
      exp_q.push_back(32'd0);
      chk("mid_cleared_nb", db_rd[31:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
